// File: rtl/flag_register_stack.sv
// Status-flag register with per-bit write enables and a LIFO save/restore stack.
// Define FLAG_STACK_ERR_EN to build the sticky ovf_err/unf_err registers.
module flag_register_stack #(
   parameter int NUM_FLAGS   = 4,
   parameter int STACK_DEPTH = 4,
   localparam int CNT_W      = $clog2(STACK_DEPTH + 1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_FLAGS-1:0] flags_in,
   input  logic [NUM_FLAGS-1:0] flag_we,
   input  logic                 push,
   input  logic                 pop,
   output logic [NUM_FLAGS-1:0] flags_out,
   output logic [CNT_W-1:0]     stack_count,
   output logic                 stack_full,
   output logic                 stack_empty,
   output logic                 ovf_err,
   output logic                 unf_err
);

   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

   logic [NUM_FLAGS-1:0] flags_q, flags_d;
   logic [NUM_FLAGS-1:0] stack_q [STACK_DEPTH];
   logic [NUM_FLAGS-1:0] stack_d [STACK_DEPTH];
   logic [CNT_W-1:0]     count_q, count_d;

   logic                 full, empty;
   logic [IDX_W-1:0]     wr_idx, top_idx;
   logic [NUM_FLAGS-1:0] merged;
   logic                 op_swap, op_rest, op_unf, op_save, op_ovf;

   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);
   assign wr_idx  = IDX_W'(count_q);
   assign top_idx = IDX_W'(count_q - CNT_W'(1));
   assign merged  = (flags_q & ~flag_we) | (flags_in & flag_we);

   // Mutually exclusive operation decode; push+pop on empty falls to op_unf
   assign op_swap = push & pop & ~empty;
   assign op_rest = pop & ~push & ~empty;
   assign op_unf  = pop & empty;
   assign op_save = push & ~pop & ~full;
   assign op_ovf  = push & ~pop & full;

   always_comb begin
      flags_d = flags_q;
      count_d = count_q;
      stack_d = stack_q;
      unique case (1'b1)
         op_swap: begin
            flags_d          = stack_q[top_idx];
            stack_d[top_idx] = flags_q;
         end
         op_rest: begin
            flags_d = stack_q[top_idx];
            count_d = count_q - CNT_W'(1);
         end
         op_save: begin
            stack_d[wr_idx] = flags_q;
            flags_d         = merged;
            count_d         = count_q + CNT_W'(1);
         end
         default: flags_d = merged;
      endcase
   end

   always_ff @(negedge clock) begin
      if (reset) begin
         flags_q <= '0;
         count_q <= '0;
         for (int i = 0; i < STACK_DEPTH; i++) begin
            stack_q[i] <= '0;
         end
      end else begin
         flags_q <= flags_d;
         count_q <= count_d;
         stack_q <= stack_d;
      end
   end

   assign flags_out   = flags_q;
   assign stack_count = count_q;
   assign stack_full  = full;
   assign stack_empty = empty;

`ifdef FLAG_STACK_ERR_EN
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;

   always_comb begin
      ovf_d = ovf_q | op_ovf;
      unf_d = unf_q | op_unf;
   end

   always_ff @(negedge clock) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign ovf_err = ovf_q;
   assign unf_err = unf_q;
`else
   logic unused_err_ev;
   assign unused_err_ev = op_ovf | op_unf;
   assign ovf_err       = 1'b0;
   assign unf_err       = 1'b0;
`endif

endmodule
